// File: rtl/task_op_issuer.sv
// task_op_issuer: queues task-op commands and serialises them onto the per-node
// 16-bit op buses as a held command word followed by an idle (zero) word.
//
// Command handshake: a command transfers on a rising CLK edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on registered state (FIFO not full),
// and the source must hold the command fields stable while cmd_valid waits for cmd_ready.
module task_op_issuer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_node,
    input  logic [3:0]                    cmd_task_id,
    input  logic [3:0]                    cmd_opcode,
    input  logic [3:0]                    cmd_arg,
    output logic [15:0]                   out_op_node0,
    output logic [15:0]                   out_op_node1,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_opcode,
    output logic [1:0]                    dbg_state
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // FIFO entry layout: {node[1:0], task_id[3:0], opcode[3:0], arg[3:0]}
    logic [13:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    state_t           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [15:0]      r_op0;
    logic [15:0]      r_op1;
    logic [3:0]       r_tag0;
    logic [3:0]       r_tag1;
    logic             r_err;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [13:0] w_head;
    logic        w_sel0;
    logic        w_sel1;

    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = cmd_valid && !w_full;
    // Opcode 0 would look like an idle word on the bus, so it is never queued.
    assign w_push   = w_accept && (cmd_opcode != 4'h0);
    // Pop only when the bus is free: from IDLE, or at the last GAP cycle.
    assign w_pop    = !w_empty && ((r_state == S_IDLE) ||
                                   ((r_state == S_GAP) && (r_tmr == '0)));
    assign w_head   = r_mem[r_rd_ptr];
    // Node select: 00 -> node0, 01 -> node1, 1x -> broadcast to both.
    assign w_sel0   = w_head[13] | ~w_head[12];
    assign w_sel1   = w_head[13] |  w_head[12];

    assign cmd_ready    = !w_full;
    assign busy         = (r_state != S_IDLE) || !w_empty;
    assign fifo_count   = r_count;
    assign err_opcode   = r_err;
    assign out_op_node0 = r_op0;
    assign out_op_node1 = r_op1;
    assign dbg_state    = r_state;

    // Storage array: written at the tail on every push; contents need no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_node, cmd_task_id, cmd_opcode, cmd_arg};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for accepted commands carrying the illegal opcode 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err <= 1'b0;
        end else if (w_accept && (cmd_opcode == 4'h0)) begin
            r_err <= 1'b1;
        end
    end

    // Bus sequencer: IDLE -> DRIVE (hold word) -> GAP (zero word) -> DRIVE or IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_op0   <= 16'h0000;
            r_op1   <= 16'h0000;
            r_tag0  <= 4'h0;
            r_tag1  <= 4'h0;
        end else if (w_pop) begin
            r_op0   <= w_sel0 ? {r_tag0, w_head[11:0]} : 16'h0000;
            r_op1   <= w_sel1 ? {r_tag1, w_head[11:0]} : 16'h0000;
            if (w_sel0) r_tag0 <= r_tag0 + 4'h1;
            if (w_sel1) r_tag1 <= r_tag1 + 4'h1;
            r_state <= S_DRIVE;
            r_tmr   <= TMR_W'(HOLD_CYCLES - 1);
        end else begin
            case (r_state)
                S_DRIVE: begin
                    if (r_tmr == '0) begin
                        r_op0   <= 16'h0000;
                        r_op1   <= 16'h0000;
                        r_state <= S_GAP;
                        r_tmr   <= TMR_W'(GAP_CYCLES - 1);
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_tmr == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                default: begin
                    r_op0   <= 16'h0000;
                    r_op1   <= 16'h0000;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task_op_issuer.sv
// Directed bench for task_op_issuer with a per-node scoreboard of expected op words.
module tb_task_op_issuer;

  localparam int HOLD = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_node = 2'b00;
  logic [3:0]  cmd_task_id = 4'h0;
  logic [3:0]  cmd_opcode = 4'h0;
  logic [3:0]  cmd_arg = 4'h0;
  logic [15:0] out_op_node0;
  logic [15:0] out_op_node1;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        err_opcode;
  logic [1:0]  dbg_state;

  task_op_issuer #(.FIFO_DEPTH(4), .HOLD_CYCLES(2), .GAP_CYCLES(1)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_node     (cmd_node),
    .cmd_task_id  (cmd_task_id),
    .cmd_opcode   (cmd_opcode),
    .cmd_arg      (cmd_arg),
    .out_op_node0 (out_op_node0),
    .out_op_node1 (out_op_node1),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .err_opcode   (err_opcode),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [3:0]  m_tag0 = 4'h0;
  logic [3:0]  m_tag1 = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: every new non-zero word must match the queue head and be held HOLD cycles
  logic [15:0] mon_prev[2];
  int          mon_run[2];

  always @(negedge CLK) begin
    logic [15:0] cur;
    logic [15:0] exp_w;
    int          qsz;
    if (!RST_N) begin
      for (int n = 0; n < 2; n++) begin
        mon_prev[n] = 16'h0;
        mon_run[n]  = 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        cur = (n == 0) ? out_op_node0 : out_op_node1;
        qsz = (n == 0) ? exp_q0.size() : exp_q1.size();
        if (cur !== 16'h0 && mon_prev[n] === 16'h0) begin
          chk($sformatf("node%0d word %h expected by scoreboard", n, cur), (qsz != 0), 1);
          if (qsz != 0) begin
            exp_w = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("node%0d word order", n), cur, exp_w);
          end
          mon_run[n] = 1;
        end else if (cur !== 16'h0) begin
          chk($sformatf("node%0d word held", n), cur, mon_prev[n]);
          mon_run[n]++;
        end else if (mon_prev[n] !== 16'h0) begin
          chk($sformatf("node%0d hold length", n), mon_run[n], HOLD);
        end
        mon_prev[n] = cur;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    RST_N = 1'b0;
    cmd_valid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    m_tag0 = 4'h0;
    m_tag1 = 4'h0;
    repeat (2) @(negedge CLK);
    chk("reset out_op_node0", out_op_node0, 16'h0);
    chk("reset out_op_node1", out_op_node1, 16'h0);
    chk("reset busy", busy, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset err_opcode", err_opcode, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] node, input logic [3:0] tid,
                      input logic [3:0] op, input logic [3:0] arg);
    int waited = 0;
    cmd_valid   = 1'b1;
    cmd_node    = node;
    cmd_task_id = tid;
    cmd_opcode  = op;
    cmd_arg     = arg;
    @(negedge CLK);
    while (cmd_ready !== 1'b1 && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    chk("command accepted within budget", (waited < 200), 1);
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    if (waited < 200 && op != 4'h0) begin
      if (node[1] || node == 2'b00) begin
        exp_q0.push_back({m_tag0, tid, op, arg});
        m_tag0 = m_tag0 + 4'h1;
      end
      if (node[1] || node == 2'b01) begin
        exp_q1.push_back({m_tag1, tid, op, arg});
        m_tag1 = m_tag1 + 4'h1;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy !== 1'b0 && i < 100) begin
      @(negedge CLK);
      i++;
    end
    chk(tag, busy, 0);
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] t2_seq[6];

  initial begin
    // T1: single node0 command, latency and frame shape
    do_reset();
    send(2'b00, 4'h2, 4'h1, 4'h0);
    chk("T1 bus before issue", out_op_node0, 16'h0);
    chk("T1 fifo_count after accept", fifo_count, 1);
    chk("T1 busy after accept", busy, 1);
    @(posedge CLK); #1;
    chk("T1 word cycle 1", out_op_node0, 16'h0210);
    chk("T1 node1 quiet", out_op_node1, 16'h0);
    @(posedge CLK); #1;
    chk("T1 word cycle 2", out_op_node0, 16'h0210);
    @(posedge CLK); #1;
    chk("T1 gap word", out_op_node0, 16'h0);
    chk("T1 busy in gap", busy, 1);
    @(posedge CLK); #1;
    chk("T1 busy back to 0", busy, 0);
    chk("T1 state idle", dbg_state, 0);

    // T2: two identical back-to-back commands, tags distinguish them
    do_reset();
    send(2'b00, 4'h2, 4'h7, 4'h0);
    send(2'b00, 4'h2, 4'h7, 4'h0);
    t2_seq[0] = 16'h0270; t2_seq[1] = 16'h0270; t2_seq[2] = 16'h0000;
    t2_seq[3] = 16'h1270; t2_seq[4] = 16'h1270; t2_seq[5] = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("T2 cycle %0d", i), out_op_node0, t2_seq[i]);
      @(posedge CLK); #1;
    end
    wait_idle("T2 idle");

    // T3: broadcast, then each tag has advanced to 1
    do_reset();
    send(2'b10, 4'h2, 4'hC, 4'h0);
    @(posedge CLK); #1;
    chk("T3 node0 cycle 1", out_op_node0, 16'h02C0);
    chk("T3 node1 cycle 1", out_op_node1, 16'h02C0);
    @(posedge CLK); #1;
    chk("T3 node0 cycle 2", out_op_node0, 16'h02C0);
    chk("T3 node1 cycle 2", out_op_node1, 16'h02C0);
    wait_idle("T3 idle after broadcast");
    send(2'b00, 4'h1, 4'h1, 4'h1);
    @(posedge CLK); #1;
    chk("T3 node0 tag 1", out_op_node0, 16'h1111);
    wait_idle("T3 idle after node0");
    send(2'b01, 4'h1, 4'h1, 4'h1);
    @(posedge CLK); #1;
    chk("T3 node1 tag 1", out_op_node1, 16'h1111);
    wait_idle("T3 idle after node1");

    // T4: stream of 8 commands to node1, FIFO fills and back-pressures
    do_reset();
    for (int a = 0; a < 8; a++) begin
      send(2'b01, 4'h4, 4'h3, 4'(a));
      if (a == 5) begin
        chk("T4 fifo_count full", fifo_count, 4);
        chk("T4 cmd_ready low when full", cmd_ready, 0);
      end
    end
    wait_idle("T4 idle");
    chk("T4 all node1 words issued", exp_q1.size(), 0);

    // T5: opcode 0 dropped, sticky error
    do_reset();
    send(2'b00, 4'h3, 4'h0, 4'h9);
    chk("T5 err_opcode set", err_opcode, 1);
    chk("T5 nothing queued", fifo_count, 0);
    chk("T5 not busy", busy, 0);
    repeat (5) @(posedge CLK);
    #1;
    chk("T5 node0 idle", out_op_node0, 16'h0);
    chk("T5 err_opcode sticky", err_opcode, 1);
    send(2'b01, 4'h3, 4'h2, 4'h9);
    wait_idle("T5 idle");
    chk("T5 err_opcode still sticky", err_opcode, 1);

    // T6: reset in the middle of a DRIVE
    do_reset();
    send(2'b00, 4'h2, 4'h5, 4'h0);
    @(posedge CLK); #1;
    chk("T6 word on bus", out_op_node0, 16'h0250);
    #1;
    RST_N = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    m_tag0 = 4'h0;
    m_tag1 = 4'h0;
    #1;
    chk("T6 node0 cleared at reset", out_op_node0, 16'h0);
    chk("T6 node1 cleared at reset", out_op_node1, 16'h0);
    chk("T6 busy cleared", busy, 0);
    chk("T6 fifo_count cleared", fifo_count, 0);
    chk("T6 cmd_ready after reset", cmd_ready, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("T6 abandoned word not re-issued", out_op_node0, 16'h0);
    send(2'b00, 4'h3, 4'h1, 4'h0);
    @(posedge CLK); #1;
    chk("T6 tag restarts at 0", out_op_node0, 16'h0310);
    wait_idle("T6 idle");

    chk("final node0 queue empty", exp_q0.size(), 0);
    chk("final node1 queue empty", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
